// File: rtl/pingpang_sched_pkg.sv
// Shared constants for the ping-pong bank scheduler: widths, read FSM
// encoding and bank indices.
package pingpang_sched_pkg;

  localparam int WR_AW_DEF = 7;
  localparam int WR_DW_DEF = 8;

  function automatic int rd_aw_of(input int wr_aw);
    return wr_aw - 1;
  endfunction

  function automatic int rd_dw_of(input int wr_dw);
    return 2 * wr_dw;
  endfunction

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  localparam logic BANK1 = 1'b0;
  localparam logic BANK2 = 1'b1;

endpackage

// File: rtl/pingpang_rd_pipe.sv
// Read return path: delays rd_en and bank select to line up with RAM q,
// then registers the selected word as data_out.
module pingpang_rd_pipe
  import pingpang_sched_pkg::*;
#(
  parameter int RD_DW = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [RD_DW-1:0] q1,
  input  logic [RD_DW-1:0] q2,
  output logic [RD_DW-1:0] data_out,
  output logic             data_out_valid
);

  logic en_d;
  logic bank_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_d           <= 1'b0;
      bank_d         <= BANK1;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      en_d           <= rd_en;
      bank_d         <= rd_bank;
      data_out_valid <= en_d;
      if (en_d) data_out <= (bank_d == BANK2) ? q2 : q1;
    end
  end

endmodule

// File: rtl/pingpang_sched.sv
// Ping-pong scheduler: fills ram1/ram2 alternately with bytes and drains
// each full bank as 16-bit words, with full-flag interlock and overflow.
module pingpang_sched
  import pingpang_sched_pkg::*;
#(
  parameter int WR_AW = WR_AW_DEF,
  parameter int WR_DW = WR_DW_DEF,
  parameter int RD_DW = rd_dw_of(WR_DW)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             data_en,
  input  logic [WR_DW-1:0] data_in,
  input  logic             out_ready,
  output logic             ram1_wr_en,
  output logic [WR_AW-1:0] ram1_wr_addr,
  output logic [WR_DW-1:0] ram1_wr_data,
  output logic             ram2_wr_en,
  output logic [WR_AW-1:0] ram2_wr_addr,
  output logic [WR_DW-1:0] ram2_wr_data,
  output logic             ram1_rd_en,
  output logic [WR_AW-2:0] ram1_rd_addr,
  output logic             ram2_rd_en,
  output logic [WR_AW-2:0] ram2_rd_addr,
  input  logic [RD_DW-1:0] ram1_rd_data,
  input  logic [RD_DW-1:0] ram2_rd_data,
  output logic [RD_DW-1:0] data_out,
  output logic             data_out_valid,
  output logic [1:0]       bank_full,
  output logic             overflow
);

  localparam int RD_AW = rd_aw_of(WR_AW);
  localparam logic [WR_AW-1:0] WR_MAX = '1;
  localparam logic [RD_AW-1:0] RD_MAX = '1;

  logic             wr_sel;
  logic [WR_AW-1:0] wr_cnt;
  logic             accept;

  assign accept = data_en && !bank_full[wr_sel];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_sel       <= BANK1;
      wr_cnt       <= '0;
      ram1_wr_en   <= 1'b0;
      ram1_wr_addr <= '0;
      ram1_wr_data <= '0;
      ram2_wr_en   <= 1'b0;
      ram2_wr_addr <= '0;
      ram2_wr_data <= '0;
      overflow     <= 1'b0;
    end else begin
      ram1_wr_en <= accept && (wr_sel == BANK1);
      ram2_wr_en <= accept && (wr_sel == BANK2);
      if (accept) begin
        if (wr_sel == BANK1) begin
          ram1_wr_addr <= wr_cnt;
          ram1_wr_data <= data_in;
        end else begin
          ram2_wr_addr <= wr_cnt;
          ram2_wr_data <= data_in;
        end
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == WR_MAX) wr_sel <= ~wr_sel;
      end
      if (data_en && !accept) overflow <= 1'b1;
    end
  end

  rd_state_e        rd_state;
  logic             rd_sel;
  logic [RD_AW-1:0] rd_cnt;
  logic             rd_last;
  logic [1:0]       full_set;
  logic [1:0]       full_clr;

  // Last word of the bank was issued on the previous edge.
  assign rd_last = (rd_sel == BANK1) ? (ram1_rd_en && ram1_rd_addr == RD_MAX)
                                     : (ram2_rd_en && ram2_rd_addr == RD_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_state     <= RD_IDLE;
      rd_sel       <= BANK1;
      rd_cnt       <= '0;
      ram1_rd_en   <= 1'b0;
      ram1_rd_addr <= '0;
      ram2_rd_en   <= 1'b0;
      ram2_rd_addr <= '0;
    end else begin
      ram1_rd_en <= 1'b0;
      ram2_rd_en <= 1'b0;
      if (rd_state == RD_IDLE) begin
        if (bank_full[rd_sel]) rd_state <= RD_READ;
      end else if (rd_last) begin
        rd_sel   <= ~rd_sel;
        rd_state <= RD_IDLE;
      end else if (out_ready) begin
        if (rd_sel == BANK1) begin
          ram1_rd_en   <= 1'b1;
          ram1_rd_addr <= rd_cnt;
        end else begin
          ram2_rd_en   <= 1'b1;
          ram2_rd_addr <= rd_cnt;
        end
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  assign full_set = {ram2_wr_en && (ram2_wr_addr == WR_MAX),
                     ram1_wr_en && (ram1_wr_addr == WR_MAX)};
  assign full_clr = {rd_last && (rd_sel == BANK2), rd_last && (rd_sel == BANK1)};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) bank_full <= 2'b00;
    else            bank_full <= (bank_full | full_set) & ~full_clr;
  end

  pingpang_rd_pipe #(.RD_DW(RD_DW)) u_rd_pipe (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .rd_en          (ram1_rd_en || ram2_rd_en),
    .rd_bank        (ram2_rd_en),
    .q1             (ram1_rd_data),
    .q2             (ram2_rd_data),
    .data_out       (data_out),
    .data_out_valid (data_out_valid)
  );

endmodule

// File: tb/tb_pingpang_sched.sv
// Bench for pingpang_sched: table vectors, directed multi-cycle sequences and
// randomized traffic checked against a transaction-level bank model.
module tb_pingpang_sched;

  localparam int DEPTH = 128;
  localparam int WORDS = 64;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        data_en = 1'b0;
  logic [7:0]  data_in = '0;
  logic        out_ready = 1'b0;
  logic        ram1_wr_en, ram2_wr_en, ram1_rd_en, ram2_rd_en;
  logic [6:0]  ram1_wr_addr, ram2_wr_addr;
  logic [7:0]  ram1_wr_data, ram2_wr_data;
  logic [5:0]  ram1_rd_addr, ram2_rd_addr;
  logic [15:0] ram1_rd_data = '0, ram2_rd_data = '0;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic [1:0]  bank_full;
  logic        overflow;

  always #5 sys_clk = ~sys_clk;

  pingpang_sched dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .data_en(data_en), .data_in(data_in), .out_ready(out_ready),
    .ram1_wr_en(ram1_wr_en), .ram1_wr_addr(ram1_wr_addr), .ram1_wr_data(ram1_wr_data),
    .ram2_wr_en(ram2_wr_en), .ram2_wr_addr(ram2_wr_addr), .ram2_wr_data(ram2_wr_data),
    .ram1_rd_en(ram1_rd_en), .ram1_rd_addr(ram1_rd_addr),
    .ram2_rd_en(ram2_rd_en), .ram2_rd_addr(ram2_rd_addr),
    .ram1_rd_data(ram1_rd_data), .ram2_rd_data(ram2_rd_data),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .bank_full(bank_full), .overflow(overflow)
  );

  // Dual-port RAM models; low byte of a word is the even address.
  logic [7:0] mem1 [DEPTH];
  logic [7:0] mem2 [DEPTH];
  always @(posedge sys_clk) begin
    if (ram1_wr_en) mem1[ram1_wr_addr] <= ram1_wr_data;
    if (ram2_wr_en) mem2[ram2_wr_addr] <= ram2_wr_data;
    if (ram1_rd_en) ram1_rd_data <= {mem1[{ram1_rd_addr, 1'b1}], mem1[{ram1_rd_addr, 1'b0}]};
    if (ram2_rd_en) ram2_rd_data <= {mem2[{ram2_rd_addr, 1'b1}], mem2[{ram2_rd_addr, 1'b0}]};
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { int due; logic [15:0] w; } exp_t;
  exp_t       expq[$];
  logic [7:0] m_mem [2][DEPTH];
  logic [1:0] m_full, m_set_pend;
  int  m_wsel, m_wcnt, m_rsel, m_rcnt, cyc;
  bit  m_ovf, m_reading, m_last;
  bit  e_wr_en [2];
  bit  e_rd_en [2];
  int  e_wr_addr [2];
  int  e_wr_data [2];
  int  e_rd_addr [2];
  int  n_rd, n_val, n_wr, last_rd, last_val;

  task automatic model_reset();
    m_full = 0; m_set_pend = 0; m_wsel = 0; m_wcnt = 0; m_rsel = 0; m_rcnt = 0;
    m_ovf = 0; m_reading = 0; m_last = 0; expq.delete();
    for (int b = 0; b < 2; b++) begin
      e_wr_en[b] = 0; e_rd_en[b] = 0;
    end
  endtask

  task automatic model_step();
    bit acc;
    logic [1:0] nf;
    cyc++;
    acc = data_en && !m_full[m_wsel];
    nf = m_full | m_set_pend;
    m_set_pend = 2'b00;
    for (int b = 0; b < 2; b++) begin
      e_wr_en[b] = 0; e_rd_en[b] = 0;
    end
    if (data_en && !acc) m_ovf = 1;
    if (acc) begin
      e_wr_en[m_wsel] = 1;
      e_wr_addr[m_wsel] = m_wcnt;
      e_wr_data[m_wsel] = int'(data_in);
      m_mem[m_wsel][m_wcnt] = data_in;
      if (m_wcnt == DEPTH - 1) begin
        m_set_pend[m_wsel] = 1'b1;
        m_wcnt = 0;
        m_wsel ^= 1;
      end else m_wcnt++;
    end
    if (!m_reading) begin
      if (m_full[m_rsel]) m_reading = 1;
    end else if (m_last) begin
      nf[m_rsel] = 1'b0;
      m_rsel ^= 1; m_reading = 0; m_last = 0; m_rcnt = 0;
    end else if (out_ready) begin
      e_rd_en[m_rsel] = 1;
      e_rd_addr[m_rsel] = m_rcnt;
      expq.push_back('{cyc + 2, {m_mem[m_rsel][2*m_rcnt+1], m_mem[m_rsel][2*m_rcnt]}});
      m_last = (m_rcnt == WORDS - 1);
      m_rcnt++;
    end
    m_full = nf;
  endtask

  task automatic compare_model();
    chk("wr1_en", 32'(ram1_wr_en), 32'(e_wr_en[0]));
    chk("wr2_en", 32'(ram2_wr_en), 32'(e_wr_en[1]));
    if (e_wr_en[0]) begin
      chk("wr1_addr", 32'(ram1_wr_addr), 32'(e_wr_addr[0]));
      chk("wr1_data", 32'(ram1_wr_data), 32'(e_wr_data[0]));
    end
    if (e_wr_en[1]) begin
      chk("wr2_addr", 32'(ram2_wr_addr), 32'(e_wr_addr[1]));
      chk("wr2_data", 32'(ram2_wr_data), 32'(e_wr_data[1]));
    end
    chk("rd1_en", 32'(ram1_rd_en), 32'(e_rd_en[0]));
    chk("rd2_en", 32'(ram2_rd_en), 32'(e_rd_en[1]));
    if (e_rd_en[0]) chk("rd1_addr", 32'(ram1_rd_addr), 32'(e_rd_addr[0]));
    if (e_rd_en[1]) chk("rd2_addr", 32'(ram2_rd_addr), 32'(e_rd_addr[1]));
    if (expq.size() > 0 && expq[0].due == cyc) begin
      chk("out_valid", 32'(data_out_valid), 32'd1);
      chk("data_out", 32'(data_out), 32'(expq[0].w));
      void'(expq.pop_front());
    end else begin
      chk("out_valid", 32'(data_out_valid), 32'd0);
    end
    chk("bank_full", 32'(bank_full), 32'(m_full));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic observe();
    if (ram1_rd_en || ram2_rd_en) begin n_rd++; last_rd = cyc; end
    if (data_out_valid) begin n_val++; last_val = cyc; end
    if (ram1_wr_en || ram2_wr_en) n_wr++;
  endtask

  task automatic clr_obs();
    n_rd = 0; n_val = 0; n_wr = 0; last_rd = 0; last_val = 0;
  endtask

  task automatic cycle(input logic en, input logic [7:0] din, input logic rdy);
    data_en = en; data_in = din; out_ready = rdy;
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    compare_model();
    observe();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'({ram1_wr_en, ram2_wr_en}), 32'd0);
    chk({tag, "_wr_addr"}, 32'({ram1_wr_addr, ram2_wr_addr}), 32'd0);
    chk({tag, "_wr_data"}, 32'({ram1_wr_data, ram2_wr_data}), 32'd0);
    chk({tag, "_rd"}, 32'({ram1_rd_en, ram2_rd_en, ram1_rd_addr, ram2_rd_addr}), 32'd0);
    chk({tag, "_out"}, 32'({data_out_valid, data_out}), 32'd0);
    chk({tag, "_flags"}, 32'({bank_full, overflow}), 32'd0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0; data_en = 0; data_in = 0; out_ready = 0;
    repeat (2) @(negedge sys_clk);
    chk_all_zero("reset");
    sys_rst_n = 1'b1;
    model_reset();
    clr_obs();
  endtask

  typedef struct packed {
    logic en; logic [7:0] din; logic rdy;
    logic e_wr1; logic [6:0] e_addr; logic [7:0] e_data; logic [1:0] e_full;
  } vec_t;
  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b1, 7'd0, 8'h11, 2'b00};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 7'd0, 8'h00, 2'b00};
    tbl[2] = '{1'b1, 8'h22, 1'b0, 1'b1, 7'd1, 8'h22, 2'b00};
    tbl[3] = '{1'b1, 8'h33, 1'b1, 1'b1, 7'd2, 8'h33, 2'b00};
    tbl[4] = '{1'b0, 8'hff, 1'b0, 1'b0, 7'd0, 8'h00, 2'b00};
    tbl[5] = '{1'b0, 8'hee, 1'b1, 1'b0, 7'd0, 8'h00, 2'b00};
    tbl[6] = '{1'b1, 8'h44, 1'b1, 1'b1, 7'd3, 8'h44, 2'b00};
    tbl[7] = '{1'b1, 8'h55, 1'b0, 1'b1, 7'd4, 8'h55, 2'b00};
    cyc = 0;
    model_reset();
    clr_obs();

    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].en, tbl[i].din, tbl[i].rdy);
      chk("tbl_wr1_en", 32'(ram1_wr_en), 32'(tbl[i].e_wr1));
      if (tbl[i].e_wr1) begin
        chk("tbl_wr1_addr", 32'(ram1_wr_addr), 32'(tbl[i].e_addr));
        chk("tbl_wr1_data", 32'(ram1_wr_data), 32'(tbl[i].e_data));
      end
      chk("tbl_wr2_en", 32'(ram2_wr_en), 32'd0);
      chk("tbl_full", 32'(bank_full), 32'(tbl[i].e_full));
    end

    // One full bank, then drain.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("a_full_after_fill", 32'(bank_full), 32'b01);
    for (int i = 0; i < 200; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("a_rd_count", 32'(n_rd), 32'(WORDS));
    chk("a_valid_count", 32'(n_val), 32'(WORDS));
    chk("a_full_drained", 32'(bank_full), 32'b00);

    // Continuous 256 bytes.
    do_reset();
    for (int i = 0; i < 2 * DEPTH; i++) cycle(1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 250; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("b_valid_count", 32'(n_val), 32'(2 * WORDS));
    chk("b_overflow", 32'(overflow), 32'd0);
    chk("b_full", 32'(bank_full), 32'b00);

    // Stalled reader, 300 bytes.
    do_reset();
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'(i * 7), 1'b0);
    chk("c_full_both", 32'(bank_full), 32'b11);
    chk("c_wr_count", 32'(n_wr), 32'(2 * DEPTH));
    chk("c_overflow_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 350; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("c_overflow_sticky", 32'(overflow), 32'd1);
    chk("c_full_drained", 32'(bank_full), 32'b00);
    chk("c_valid_count", 32'(n_val), 32'(2 * WORDS));

    // Reader throttled by alternating out_ready.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(255 - i), 1'(i));
    for (int i = 0; i < 250; i++) cycle(1'b0, 8'h00, 1'(i));
    chk("d_rd_count", 32'(n_rd), 32'(WORDS));
    chk("d_valid_count", 32'(n_val), 32'(WORDS));
    chk("d_last_valid_gap", 32'(last_val - last_rd), 32'd2);

    // Sparse writer: data_en every 4th cycle.
    do_reset();
    for (int i = 0; i < 4 * DEPTH; i++) cycle(1'((i % 4) == 0), 8'(i / 4 + 3), 1'b1);
    chk("e_wr_count", 32'(n_wr), 32'(DEPTH));
    cycle(1'b0, 8'h00, 1'b1);
    chk("e_full_after_fill", 32'(bank_full), 32'b01);
    for (int i = 0; i < 150; i++) cycle(1'b0, 8'h00, 1'b1);

    // Asynchronous reset while the reader is at word 30.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i ^ 8'h5a), 1'b1);
    for (int i = 0; i < 300 && n_rd < 30; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("f_reached_word30", 32'(n_rd), 32'd30);
    #2 sys_rst_n = 1'b0;
    #1 chk_all_zero("f_async");
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cycle(1'b1, 8'ha5, 1'b1);
    chk("f_restart_wr1_en", 32'(ram1_wr_en), 32'd1);
    chk("f_restart_addr", 32'(ram1_wr_addr), 32'd0);
    chk("f_restart_full", 32'(bank_full), 32'b00);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 9) < 6));
    for (int i = 0; i < 400; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("r_queue_empty", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
